// File: rtl/cpc_ram_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpc_ram_bank_ctrl
//  Description : CPC RAM expansion banking. Snoops gate-array config writes
//                and decodes memory requests into SRAM select/high address.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpc_ram_bank_ctrl #(
    parameter int BANK_BITS     = 3,
    parameter bit RFSH_SUPPRESS = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 A15,
    input  logic                 A14,
    input  logic [7:0]           D,
    input  logic                 IOREQ_B,
    input  logic                 WR_B,
    input  logic                 MREQ_B,
    input  logic                 RFSH_B,
    output logic                 ramcs_b,
    output logic                 RAMDIS,
    output logic [BANK_BITS+1:0] hiadr,
    output logic [2:0]           cfg_mode,
    output logic [2:0]           cfg_bank,
    output logic                 cfg_wr_pulse
);

    localparam logic [0:0] c_st_idle     = 1'b0;
    localparam logic [0:0] c_st_wait_end = 1'b1;
    localparam logic [3:0] c_bank_limit  = 4'(1 << BANK_BITS);

    logic       r_a15_q;
    logic       r_ioreq_b_q;
    logic       r_wr_b_q;
    logic [7:0] r_d_q;
    logic [0:0] r_state;
    logic [2:0] r_cfg_mode;
    logic [2:0] r_cfg_bank;
    logic       r_cfg_wr_pulse;

    logic       w_io_wr;
    logic       w_strobes_low;
    logic [1:0] w_region;
    logic [1:0] w_blk;
    logic       w_mapped;
    logic       w_bank_ok;
    logic       w_rfsh_ok;
    logic       w_hit;

    assign w_strobes_low = ~r_ioreq_b_q & ~r_wr_b_q;
    assign w_io_wr       = w_strobes_low & ~r_a15_q & (r_d_q[7:6] == 2'b11);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_a15_q     <= 1'b0;
            r_ioreq_b_q <= 1'b1;
            r_wr_b_q    <= 1'b1;
            r_d_q       <= 8'h00;
        end else begin
            r_a15_q     <= A15;
            r_ioreq_b_q <= IOREQ_B;
            r_wr_b_q    <= WR_B;
            r_d_q       <= D;
        end
    end

    // A held write is taken once; re-arming needs a sampled idle strobe.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= c_st_idle;
            r_cfg_mode     <= 3'd0;
            r_cfg_bank     <= 3'd0;
            r_cfg_wr_pulse <= 1'b0;
        end else begin
            r_cfg_wr_pulse <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_io_wr) begin
                        r_cfg_mode     <= r_d_q[2:0];
                        r_cfg_bank     <= r_d_q[5:3];
                        r_cfg_wr_pulse <= 1'b1;
                        r_state        <= c_st_wait_end;
                    end
                end
                default: begin
                    if (!w_strobes_low) begin
                        r_state <= c_st_idle;
                    end
                end
            endcase
        end
    end

    assign w_region = {A15, A14};

    always_comb begin
        w_mapped = 1'b0;
        w_blk    = w_region;
        case (r_cfg_mode)
            3'd1, 3'd3: begin
                if (w_region == 2'b11) begin
                    w_mapped = 1'b1;
                end
            end
            3'd2: begin
                w_mapped = 1'b1;
            end
            default: begin
                if (r_cfg_mode[2] && (w_region == 2'b01)) begin
                    w_mapped = 1'b1;
                    w_blk    = r_cfg_mode[1:0];
                end
            end
        endcase
    end

    assign w_bank_ok = ({1'b0, r_cfg_bank} < c_bank_limit);
    assign w_rfsh_ok = RFSH_B | ~RFSH_SUPPRESS;
    assign w_hit     = ~MREQ_B & w_mapped & w_bank_ok & w_rfsh_ok;

    assign ramcs_b      = ~w_hit;
    assign RAMDIS       = w_hit;
    assign hiadr        = {r_cfg_bank[BANK_BITS-1:0], w_blk};
    assign cfg_mode     = r_cfg_mode;
    assign cfg_bank     = r_cfg_bank;
    assign cfg_wr_pulse = r_cfg_wr_pulse;

endmodule
`default_nettype wire

// File: doc/cpc_ram_bank_ctrl.md
Name: cpc_ram_bank_ctrl

Overview:
- Synchronous single-clock replacement for the discrete 74-series RAM banking logic on the CPC RAM expansion board. Intended as a CPLD implementation.
- Snoops Z80 I/O writes to the gate-array port (A15=0, D7:D6=11) and latches the RAM configuration byte.
- Decodes each memory request into an external-SRAM chip select, the SRAM high address lines and the RAMDIS signal back to the host.

Parameters:
- BANK_BITS, 3, number of 64KB bank-select bits taken from D5:D3 (legal 1..3). SRAM size is 2^BANK_BITS x 64KB.
- RFSH_SUPPRESS, 1, when 1 the SRAM is not selected during Z80 refresh cycles (RFSH_B=0).

Ports:
- CLK  in  1  CPC bus clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- A15  in  1  Z80 address bit 15.
- A14  in  1  Z80 address bit 14.
- D  in  8  Z80 data bus.
- IOREQ_B  in  1  Z80 I/O request, active low.
- WR_B  in  1  Z80 write strobe, active low.
- MREQ_B  in  1  Z80 memory request, active low.
- RFSH_B  in  1  Z80 refresh, active low.
- ramcs_b  out  1  SRAM chip select, active low.
- RAMDIS  out  1  high disables the host's internal RAM for the current access.
- hiadr  out  BANK_BITS+2  SRAM high address: {bank, block}.
- cfg_mode  out  3  latched config mode c (D2:D0).
- cfg_bank  out  3  latched bank b (D5:D3).
- cfg_wr_pulse  out  1  one-cycle strobe on each accepted config write.

Behaviour:
- Reset values (RESET=1 at an edge):
  - cfg_mode=0, cfg_bank=0, cfg_wr_pulse=0, FSM=IDLE.
  - Input sample registers set to the inactive level (IOREQ_B_q=1, WR_B_q=1, others 0).
  - With mode 0, ramcs_b=1 and RAMDIS=0 regardless of the bus.
- Input sampling: A15, IOREQ_B, WR_B and D are registered once per rising edge into *_q. The config path uses only *_q.
- io_wr = !IOREQ_B_q & !WR_B_q & !A15_q & (D_q[7:6]==2'b11).
  - Any other I/O write (pen/mode/ROM writes, A15=1) is ignored.
- Config FSM, two states:
  - IDLE: if io_wr, load cfg_mode<=D_q[2:0] and cfg_bank<=D_q[5:3], assert cfg_wr_pulse for the following cycle only, then go to WAIT_END. Otherwise stay.
  - WAIT_END: stay while IOREQ_B_q=0 and WR_B_q=0, else go to IDLE. A write held for many cycles is accepted exactly once; a new write needs at least one sampled cycle with IOREQ_B or WR_B high.
- Latency: the bus write is asserted before edge N. It is sampled at N. cfg and cfg_wr_pulse update at N+1.
- Memory decode is combinational from live A15, A14, MREQ_B, RFSH_B and the registered cfg. Region r = {A15,A14}.
  - mode 0: no region mapped.
  - mode 1: r=3 maps to block 3.
  - mode 2: all r map to block r.
  - mode 3: r=3 maps to block 3. Region 1 is not expanded (the host's internal remap handles it).
  - modes 4..7: r=1 maps to block (c-4).
- bank_ok = (cfg_bank < 2^BANK_BITS). An out-of-range bank disables all expansion mapping.
- hit = !MREQ_B & mapped(r) & bank_ok & (RFSH_B | !RFSH_SUPPRESS).
  - ramcs_b = !hit; RAMDIS = hit.
- hiadr = {cfg_bank[BANK_BITS-1:0], blk}.
  - blk is the mapped block when the region is mapped, else {A15,A14}.
  - hiadr is always driven but is only meaningful when ramcs_b=0.
- Config change during MREQ: the decode switches in the same cycle cfg updates. No glitch-hold is required.
- Reset mid-write: the FSM returns to IDLE and cfg clears. If the I/O write is still sampled active after RESET falls, it is accepted again.
- Simultaneous config write and memory request: both are handled independently. The decode uses the old cfg until edge N+1.

Test Plan:
- Reset, then MREQ_B=0 with A15:A14=11 -> ramcs_b=1, RAMDIS=0, cfg_mode=0, cfg_bank=0.
- I/O write D=0xC1 (A15=0), held 1 cycle -> cfg_mode=1 and cfg_wr_pulse=1 at N+1 for exactly one cycle. Then MREQ at 0xC000 -> ramcs_b=0, RAMDIS=1, hiadr=5'b00011.
- I/O write D=0xEE (b=5, c=6), held 4 cycles -> one cfg_wr_pulse only. MREQ at 0x4000 -> hiadr=5'b10110, ramcs_b=0. MREQ at 0xC000 -> ramcs_b=1.
- Mode 2, bank 7 (D=0xFA): sweep A15:A14=00..11 -> hiadr=11100, 11101, 11110, 11111. Same accesses with RFSH_B=0 -> ramcs_b=1.
- Non-matching writes: D=0x8C (D7:D6=10), and D=0xC4 with A15=1 -> cfg unchanged, no pulse.
- BANK_BITS=2 build, D=0xE4 (b=4, c=4): MREQ at 0x4000 -> ramcs_b=1 (bank out of range). RESET asserted while an I/O write is held -> cfg=0; after RESET falls, the write is recaptured one cycle later.
